// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and types for the seven-segment port scanner
package sevenseg_pkg;

   localparam logic [2:0] DIGIT0 = 3'd0;
   localparam logic [2:0] DIGIT1 = 3'd1;
   localparam logic [2:0] DIGIT2 = 3'd2;
   localparam logic [2:0] DIGIT3 = 3'd3;
   localparam logic [2:0] DPMASK = 3'd4;
   localparam logic [2:0] CTRL   = 3'd5;
   localparam logic [2:0] STATUS = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_e;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/sevenseg_port_scanner_if.sv
// rtl/sevenseg_port_scanner_if.sv - kcpsm6 output-port write bus plus readback byte
interface sevenseg_port_scanner_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic [7:0] rd_data;

   modport master (output port_id, output out_port, output write_strobe, input rd_data);
   modport slave  (input port_id, input out_port, input write_strobe, output rd_data);
endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex digit to active-low {g,f,e,d,c,b,a} decoder
module hex_to_seg7 (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h7F;
      case (hex_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/sevenseg_port_scanner.sv
// rtl/sevenseg_port_scanner.sv - PicoBlaze port peripheral scanning a 4-digit common-anode display
module sevenseg_port_scanner
   import sevenseg_pkg::*;
#(
   parameter int         DIV       = 50000,
   parameter int         BLANK     = 500,
   parameter logic [7:0] BASE_PORT = 8'h20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   sevenseg_port_scanner_if.slave   bus,
   output logic [3:0]               an,
   output logic [7:0]               seg,
   output logic                     frame_tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'(BLANK - 1);

   logic [4:0]    digit_q [4];
   logic [3:0]    dp_q;
   logic          en_q;
   state_e        state_q, state_d;
   logic [1:0]    cur_q, cur_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [3:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    rd_q, rd_d;
   logic [3:0]    cur_hex;
   logic [6:0]    seg7;

   logic       sel;
   logic       wr;
   logic [2:0] off;

   assign sel = (bus.port_id[7:3] == BASE_PORT[7:3]);
   assign wr  = bus.write_strobe & sel;
   assign off = bus.port_id[2:0];

   wire unused_ok = &{1'b0, bus.out_port[7:5], BASE_PORT[2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) digit_q[i] <= '0;
         dp_q <= '0;
         en_q <= 1'b0;
      end else if (wr) begin
         case (off)
            DIGIT0, DIGIT1, DIGIT2, DIGIT3: digit_q[off[1:0]] <= bus.out_port[4:0];
            DPMASK: dp_q <= bus.out_port[3:0];
            CTRL:   en_q <= bus.out_port[0];
            default: ;
         endcase
      end
   end

   // The counter spans the whole slot: BLANK covers 0..BLANK-1, DRIVE the rest.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      if (!en_q) begin
         state_d = S_IDLE;
         cur_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               cur_d   = '0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLK_LAST) state_d = S_DRIVE;
            end
            S_DRIVE: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  cur_d   = cur_q + 2'd1;
                  state_d = S_BLANK;
                  tick_d  = (cur_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cur_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cur_hex = digit_q[cur_d][3:0];

   hex_to_seg7 u_dec (
      .hex_i (cur_hex),
      .seg_o (seg7)
   );

   // Outputs follow the next state so anodes and segments switch on the same edge as the FSM.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      if (state_d == S_DRIVE) begin
         an_d = ~(4'b0001 << cur_d);
         if (!digit_q[cur_d][4]) seg_d = {~dp_q[cur_d], seg7};
      end
   end

   always_comb begin
      rd_d = 8'h00;
      if (sel) begin
         case (off)
            DIGIT0, DIGIT1, DIGIT2, DIGIT3: rd_d = {3'b000, digit_q[off[1:0]]};
            DPMASK: rd_d = {4'b0000, dp_q};
            CTRL:   rd_d = {7'b0000000, en_q};
            STATUS: rd_d = {4'b0000, cur_q, state_q};
            default: rd_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q   <= AN_OFF;
         seg_q  <= SEG_OFF;
         tick_q <= 1'b0;
         rd_q   <= 8'h00;
      end else begin
         an_q   <= an_d;
         seg_q  <= seg_d;
         tick_q <= tick_d;
         rd_q   <= rd_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_tick  = tick_q;
   assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_sevenseg_port_scanner.sv
// tb/tb_sevenseg_port_scanner.sv - randomized self-checking bench for sevenseg_port_scanner
module tb_sevenseg_port_scanner;

   localparam int DIV = 8;
   localparam int BLK = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] an;
   logic [7:0] seg;
   logic       frame_tick;

   sevenseg_port_scanner_if bus ();

   sevenseg_port_scanner #(.DIV(DIV), .BLANK(BLK), .BASE_PORT(8'h20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register file plus a scan time measured from the first BLANK cycle.
   logic [4:0] m_dig [4];
   logic [3:0] m_dp;
   logic       m_en;
   bit         running;
   int         scan_t;
   logic [7:0] prev_status;
   bit         s_run;
   int         s_t;
   int         ticks;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = '0;
      m_dp = '0; m_en = 1'b0; running = 0; scan_t = 0; prev_status = 8'h00;
      s_run = 0; s_t = 0;
   endtask

   function automatic logic [7:0] model_rd(input logic [7:0] p);
      if (p[7:3] != 5'b00100) return 8'h00;
      case (p[2:0])
         3'd0, 3'd1, 3'd2, 3'd3: return {3'b000, m_dig[p[1:0]]};
         3'd4: return {4'b0000, m_dp};
         3'd5: return {7'b0000000, m_en};
         3'd6: return prev_status;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] rnd_port();
      int r = $urandom_range(0, 9);
      if (r < 8) return 8'h20 + 8'(r);
      if (r == 8) return 8'h10;
      return 8'h40 + 8'($urandom_range(0, 7));
   endfunction

   // One clock: drive inputs, sample after the edge, compare against the model, then commit writes.
   task automatic step(input bit wr, input logic [7:0] p, input logic [7:0] d);
      logic [3:0] e_an;
      logic [7:0] e_seg, e_rd;
      logic       e_tick;
      int dg, ph;
      bus.port_id = p; bus.out_port = d; bus.write_strobe = wr;
      e_rd = model_rd(p);
      @(posedge clk); #1;
      dg = (scan_t / DIV) % 4;
      ph = scan_t % DIV;
      e_an = 4'hF; e_seg = 8'hFF;
      if (running && ph >= BLK) begin
         e_an = ~(4'b0001 << dg);
         e_seg = m_dig[dg][4] ? 8'hFF : {~m_dp[dg], HEX[m_dig[dg][3:0]]};
      end
      e_tick = running && scan_t > 0 && (scan_t % (4 * DIV)) == 0;
      n_tests++;
      if (an !== e_an) begin n_fail++; $display("FAIL model_an t=%0d: got %h expected %h", scan_t, an, e_an); end
      n_tests++;
      if (seg !== e_seg) begin n_fail++; $display("FAIL model_seg t=%0d: got %h expected %h", scan_t, seg, e_seg); end
      n_tests++;
      if (frame_tick !== e_tick) begin n_fail++; $display("FAIL model_tick t=%0d: got %b expected %b", scan_t, frame_tick, e_tick); end
      n_tests++;
      if (bus.rd_data !== e_rd) begin n_fail++; $display("FAIL model_rd port=%h: got %h expected %h", p, bus.rd_data, e_rd); end
      if (frame_tick === 1'b1) ticks++;
      s_run = running; s_t = scan_t;
      prev_status = running ? {4'b0000, 2'(dg), (ph < BLK) ? 2'd1 : 2'd2} : 8'h00;
      if (running) scan_t++;
      if (wr && p[7:3] == 5'b00100) begin
         case (p[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: m_dig[p[1:0]] = d[4:0];
            3'd4: m_dp = d[3:0];
            3'd5: begin
               m_en = d[0];
               if (!d[0]) running = 0;
               else if (!running) begin running = 1; scan_t = 0; end
            end
            default: ;
         endcase
      end
      @(negedge clk);
      bus.write_strobe = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, rnd_port(), 8'($urandom));
   endtask

   // Step until the last sampled cycle is the first DRIVE cycle of digit dg.
   task automatic goto_slot(input int dg);
      int k = 0;
      do begin
         step(0, rnd_port(), 8'h00);
         k++;
      end while (!(s_run && ((s_t / DIV) % 4) == dg && (s_t % DIV) == BLK) && k < 100);
      if (k >= 100) begin
         n_tests++; n_fail++;
         $display("FAIL goto_slot%0d: got timeout expected slot reached", dg);
      end
   endtask

   task automatic test_reset();
      bus.port_id = 8'h00; bus.out_port = 8'h00; bus.write_strobe = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_tests++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected F", an); end
      n_tests++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h expected FF", seg); end
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h expected 00", bus.rd_data); end
      n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
      rst_n = 1'b1;
      step(0, 8'h25, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00", bus.rd_data); end
      step(0, 8'h26, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", bus.rd_data); end
   endtask

   task automatic test_scan();
      step(1, 8'h20, 8'h01); step(1, 8'h21, 8'h02);
      step(1, 8'h22, 8'h03); step(1, 8'h23, 8'h04);
      step(1, 8'h25, 8'h01);
      ticks = 0;
      run(64);
      n_tests++; if (ticks !== 1) begin n_fail++; $display("FAIL scan_ticks64: got %0d expected 1", ticks); end
      run(32);
      n_tests++; if (ticks !== 2) begin n_fail++; $display("FAIL scan_ticks96: got %0d expected 2", ticks); end
      goto_slot(0);
      n_tests++; if ({an, seg} !== 12'hEF9) begin n_fail++; $display("FAIL scan_d0: got %h expected EF9", {an, seg}); end
      goto_slot(1);
      n_tests++; if ({an, seg} !== 12'hDA4) begin n_fail++; $display("FAIL scan_d1: got %h expected DA4", {an, seg}); end
      goto_slot(2);
      n_tests++; if ({an, seg} !== 12'hBB0) begin n_fail++; $display("FAIL scan_d2: got %h expected BB0", {an, seg}); end
      goto_slot(3);
      n_tests++; if ({an, seg} !== 12'h799) begin n_fail++; $display("FAIL scan_d3: got %h expected 799", {an, seg}); end
      step(1, 8'h25, 8'h01);
      run(3);
      n_tests++; if (!s_run || s_t < BLK + 4) begin n_fail++; $display("FAIL scan_reenable: got t=%0d expected no restart", s_t); end
   endtask

   task automatic test_dp_blank();
      step(1, 8'h24, 8'h05);
      step(1, 8'h20, 8'h08);
      goto_slot(0);
      n_tests++; if (seg !== 8'h00) begin n_fail++; $display("FAIL dp_d0: got %h expected 00", seg); end
      goto_slot(2);
      n_tests++; if (seg !== 8'h30) begin n_fail++; $display("FAIL dp_d2: got %h expected 30", seg); end
      step(1, 8'h21, 8'h10);
      goto_slot(1);
      n_tests++; if ({an, seg} !== 12'hDFF) begin n_fail++; $display("FAIL blank_d1: got %h expected DFF", {an, seg}); end
      run(10);
   endtask

   task automatic test_disable();
      goto_slot(2);
      step(0, 8'h26, 8'h00);
      step(1, 8'h25, 8'h00);
      step(0, 8'h26, 8'h00);
      n_tests++; if ({an, seg} !== 12'hFFF) begin n_fail++; $display("FAIL disable_out: got %h expected FFF", {an, seg}); end
      step(0, 8'h26, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL disable_status: got %h expected 00", bus.rd_data); end
      ticks = 0;
      run(40);
      n_tests++; if (ticks !== 0) begin n_fail++; $display("FAIL disable_ticks: got %0d expected 0", ticks); end
   endtask

   task automatic test_readback();
      step(1, 8'h22, 8'hAB);
      step(0, 8'h22, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h0B) begin n_fail++; $display("FAIL rd_22: got %h expected 0B", bus.rd_data); end
      step(0, 8'h27, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_27: got %h expected 00", bus.rd_data); end
      step(0, 8'h10, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_10: got %h expected 00", bus.rd_data); end
      step(1, 8'h42, 8'h1F);
      step(0, 8'h22, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h0B) begin n_fail++; $display("FAIL rd_foreign: got %h expected 0B", bus.rd_data); end
      step(1, 8'h23, 8'h07);
      n_tests++; if (bus.rd_data !== 8'h04) begin n_fail++; $display("FAIL rd_same_pre: got %h expected 04", bus.rd_data); end
      step(0, 8'h23, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h07) begin n_fail++; $display("FAIL rd_same_post: got %h expected 07", bus.rd_data); end
      step(1, 8'h26, 8'hFF);
      step(1, 8'h27, 8'hFF);
      run(4);
   endtask

   task automatic test_hex_sweep();
      step(1, 8'h24, 8'h00);
      step(1, 8'h25, 8'h01);
      for (int v = 0; v < 16; v++) begin
         step(1, 8'h20, 8'(v));
         goto_slot(0);
         n_tests++;
         if (seg[6:0] !== HEX[v]) begin n_fail++; $display("FAIL hex_%0h: got %h expected %h", v, seg[6:0], HEX[v]); end
      end
   endtask

   task automatic test_async_reset();
      goto_slot(1);
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({an, seg} !== 12'hFFF) begin n_fail++; $display("FAIL areset_out: got %h expected FFF", {an, seg}); end
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL areset_rd: got %h expected 00", bus.rd_data); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(0, 8'h25, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL areset_ctrl: got %h expected 00", bus.rd_data); end
      step(0, 8'h26, 8'h00);
      n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL areset_status: got %h expected 00", bus.rd_data); end
   endtask

   task automatic test_random();
      logic [7:0] p, d;
      step(1, 8'h25, 8'h01);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            p = rnd_port();
            d = 8'($urandom);
            if (p == 8'h25) d[0] = ($urandom_range(0, 3) != 0);
            step(1, p, d);
         end else begin
            step(0, rnd_port(), 8'($urandom));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_scan();
      test_dp_blank();
      test_disable();
      test_readback();
      test_hex_sweep();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sevenseg_port_scanner.md
Name: sevenseg_port_scanner

Overview:
- PicoBlaze output-port peripheral. Takes the kcpsm6 write bus (port_id/out_port/write_strobe) and drives a 4-digit common-anode seven-segment display autonomously.
- Firmware writes 4 hex digit registers, a decimal-point mask and a control register. The block time-multiplexes the anodes with a blanking gap between digits to suppress ghosting.
- It also returns a registered readback byte for the top-level in_port mux.

Parameters:
- DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); must satisfy DIV > BLANK.
- BLANK, 500: cycles at the start of each slot with all anodes off; must be >= 1.
- BASE_PORT, 8'h20: port base address; must be a multiple of 8. Decode is port_id[7:3] == BASE_PORT[7:3].

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- port_id  in  8  kcpsm6 port address.
- out_port  in  8  kcpsm6 write data.
- write_strobe  in  1  kcpsm6 write qualifier.
- an  out  4  anode enables, active-low, an[0] = rightmost digit.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- rd_data  out  8  registered readback for the in_port mux.
- frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- Register map (offset = port_id[2:0]):
  - 0–3: digit n; bits[3:0] = hex value, bit4 = blank this digit, bits[7:5] ignored.
  - 4: dp mask; bit n lights the dp of digit n.
  - 5: control; bit0 = enable.
  - 6: status, read-only, {4'b0, cur_digit[1:0], state[1:0]}.
  - 7: unused.
- Register writes occur on the rising clk edge where write_strobe=1 and the base matches. Writes to offsets 6–7 are ignored.
- rd_data:
  - Updated every cycle with the register selected by port_id; latency 1 cycle, matching the kcpsm6 read timing.
  - Unused bits read 0.
  - Offset 7 and a non-matching base return 8'h00.
- Reset (async assert, sync release): all registers 0, state=IDLE, cur_digit=0, counter=0, an=4'hF, seg=8'hFF, rd_data=8'h00, frame_tick=0.
- FSM, states IDLE=0, BLANK=1, DRIVE=2:
  - IDLE: an=F, seg=FF. Go to BLANK with cur_digit=0 and counter=0 on the cycle after enable reads 1.
  - BLANK: an=F, seg=FF. Counter increments; at counter==BLANK-1 go to DRIVE.
  - DRIVE: an = ~(1<<cur_digit); seg = {~dp[cur], hex7(value)}, or 8'hFF if the blank bit is set. At counter==DIV-1, counter resets to 0, cur_digit increments modulo 4, and the state returns to BLANK.
  - In any state, enable=0 forces IDLE on the next edge; outputs are blank one cycle after the disabling write.
- frame_tick pulses 1 for exactly one cycle, coincident with the DRIVE->BLANK transition out of digit 3.
- an and seg are registered.
  - A register write mid-DRIVE shows on seg one cycle after the write edge. No tearing of anodes.
  - Writing enable=1 while already enabled does not restart the scan.
- hex7 (active-low g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Counter width is $clog2(DIV); counter wrap is explicit, with no reliance on overflow.
- Simultaneous write and read to the same offset: rd_data returns the pre-write value that cycle and the new value the next cycle.

Decomposition:
- Shared package sevenseg_pkg holds:
  - register offset constants (DIGIT0..3, DPMASK, CTRL, STATUS);
  - the state enum (IDLE/BLANK/DRIVE, 2 bits);
  - SEG_OFF = 8'hFF and AN_OFF = 4'hF.
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit active-low decoder, reused by future display blocks.

Test Plan (DIV=8, BLANK=2, BASE_PORT=8'h20):
- Reset held low mid-DRIVE -> an=F and seg=FF immediately (asynchronous). After release, rd_data at port 8'h25 = 00, and status = 00.
- Write 20=0x1, 21=0x2, 22=0x3, 23=0x4, 25=01 -> BLANK for 2 cycles, then an=E with seg=F9 for 6 cycles. Next digit: 2 cycles blank, then an=D with seg=A4. Then an=B with seg=B0, then an=7 with seg=99. frame_tick pulses once every 32 cycles.
- Write 24=05 and 20=0x8 -> digit 0 shows seg=00 (dp lit + 8) and digit 2 shows seg=30. Write 21=0x10 -> digit 1 shows seg=FF with an=D still asserted.
- Write 25=00 during digit 2 DRIVE -> one cycle later an=F and seg=FF. Status reads 00. No frame_tick.
- Read port 8'h22 after writing 0xAB -> rd_data=0B one cycle later. Read port 8'h27 -> 00. Read port 8'h10 -> 00. Write to 8'h40 -> no register changes.
- Sweep digit 0 through 0..F -> seg[6:0] matches the hex7 table for every value.
